// File: rtl/led_shift_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : led_shift_pkg                                           |
// | Purpose  : Shared constants, the hex-to-seven-segment lookup table |
// |            and the scan digit-content classification.              |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package led_shift_pkg;

    // Segment vectors are ordered {g,f,e,d,c,b,a}; 0 lights a segment.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // What a given scan position shows.
    typedef enum logic [2:0] {
        DIG_POS_LO = 3'd0,
        DIG_POS_HI = 3'd1,
        DIG_CNT0   = 3'd2,
        DIG_CNT1   = 3'd3,
        DIG_CNT2   = 3'd4,
        DIG_CNT3   = 3'd5,
        DIG_BLANK  = 3'd6
    } digit_kind_e;

    // Active-low hex glyphs 0-F.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] val);
        logic [6:0] seg;
        case (val)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Digits 0/1 carry the position, 2..5 the move counter, the rest are dark.
    function automatic digit_kind_e digit_kind(input logic [2:0] idx);
        digit_kind_e kind;
        case (idx)
            3'd0: kind = DIG_POS_LO;
            3'd1: kind = DIG_POS_HI;
            3'd2: kind = DIG_CNT0;
            3'd3: kind = DIG_CNT1;
            3'd4: kind = DIG_CNT2;
            3'd5: kind = DIG_CNT3;
            default: kind = DIG_BLANK;
        endcase
        return kind;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : btn_debounce                                            |
// | Purpose  : 2-flop synchroniser, stability debouncer and one-cycle  |
// |            press pulse for an active-low push button.              |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn_n,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // Bring the raw button into the clock domain; idle level is released (1).
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after DEBOUNCE_CYC consecutive disagreeing cycles.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            level <= 1'b1;
            cnt   <= '0;
        end else if (sync2 != level) begin
            if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    // Delayed copy of the debounced level for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            level_d <= 1'b1;
        end else begin
            level_d <= level;
        end
    end

    assign press = level_d & ~level;

endmodule
`default_nettype wire

// File: rtl/led_shift_disp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : led_shift_disp                                          |
// | Purpose  : Button-driven LED position shifter with a multiplexed   |
// |            seven-segment readout of position and move count.       |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module led_shift_disp
    import led_shift_pkg::*;
#(
    parameter int W_LED        = 16,
    parameter int W_7_INDIC    = 8,
    parameter int DEBOUNCE_CYC = 4,
    parameter int SCAN_DIV     = 4,
    parameter int WRAP         = 1,
    parameter int BAR_MODE     = 0
) (
    input  logic                 clk_i,
    input  logic                 arstn_i,
    input  logic                 BTNL,
    input  logic                 BTNR,
    output logic [W_7_INDIC-1:0] an_o,
    output logic [W_LED-1:0]     led_o,
    output logic                 ca_o,
    output logic                 cb_o,
    output logic                 cc_o,
    output logic                 cd_o,
    output logic                 ce_o,
    output logic                 cf_o,
    output logic                 cg_o,
    output logic                 dp_o
);

    localparam int PW = $clog2(W_LED);
    localparam int IW = $clog2(W_7_INDIC);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] POS_MAX  = PW'(W_LED - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(W_7_INDIC - 1);

    logic          press_l;
    logic          press_r;
    logic [PW-1:0] pos;
    logic [PW-1:0] pos_nxt;
    logic          move;
    logic          at_min;
    logic          at_max;
    logic [15:0]   moves;
    logic [DW-1:0] scan_div;
    logic [IW-1:0] scan_idx;
    logic [7:0]    pos8;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;
    logic [6:0]    seg;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_l (
        .clk   (clk_i),
        .rstn  (arstn_i),
        .btn_n (BTNL),
        .press (press_l)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_r (
        .clk   (clk_i),
        .rstn  (arstn_i),
        .btn_n (BTNR),
        .press (press_r)
    );

    assign at_min = (pos == '0);
    assign at_max = (pos == POS_MAX);

    // Next position; simultaneous presses cancel, ends wrap or block by WRAP.
    always_comb begin
        pos_nxt = pos;
        move    = 1'b0;
        if (press_l && !press_r) begin
            if (!at_max) begin
                pos_nxt = pos + PW'(1);
                move    = 1'b1;
            end else if (WRAP != 0) begin
                pos_nxt = '0;
                move    = 1'b1;
            end
        end else if (press_r && !press_l) begin
            if (!at_min) begin
                pos_nxt = pos - PW'(1);
                move    = 1'b1;
            end else if (WRAP != 0) begin
                pos_nxt = POS_MAX;
                move    = 1'b1;
            end
        end
    end

    // Position register and count of accepted moves.
    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            pos   <= '0;
            moves <= '0;
        end else if (move) begin
            pos   <= pos_nxt;
            moves <= moves + 16'd1;
        end
    end

    // LED pattern straight from the position: a single dot or a bar.
    for (genvar i = 0; i < W_LED; i++) begin : g_led
        localparam logic [PW-1:0] IDX = PW'(i);
        assign led_o[i] = (BAR_MODE != 0) ? (IDX <= pos) : (IDX == pos);
    end

    // Digit scan: hold each digit for SCAN_DIV cycles, then step to the next.
    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            scan_div <= '0;
            scan_idx <= '0;
        end else if (scan_div == DIV_LAST) begin
            scan_div <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
        end else begin
            scan_div <= scan_div + DW'(1);
        end
    end

    assign pos8 = 8'(pos);

    // Select the glyph for the digit currently being scanned.
    always_comb begin
        seg_nxt = SEG_BLANK;
        case (digit_kind(3'(scan_idx)))
            DIG_POS_LO: seg_nxt = hex_to_seg(pos8[3:0]);
            DIG_POS_HI: seg_nxt = hex_to_seg(pos8[7:4]);
            DIG_CNT0:   seg_nxt = hex_to_seg(moves[3:0]);
            DIG_CNT1:   seg_nxt = hex_to_seg(moves[7:4]);
            DIG_CNT2:   seg_nxt = hex_to_seg(moves[11:8]);
            DIG_CNT3:   seg_nxt = hex_to_seg(moves[15:12]);
            default:    seg_nxt = SEG_BLANK;
        endcase
    end

    // Decimal point on digit 0 flags that a saturating position sits at an end.
    assign dp_nxt = ~((scan_idx == '0) && (WRAP == 0) && (at_min || at_max));

    // Register the display drive so anodes, segments and dp switch together.
    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            an_o <= '1;
            seg  <= SEG_BLANK;
            dp_o <= 1'b1;
        end else begin
            an_o <= ~(W_7_INDIC'(1) << scan_idx);
            seg  <= seg_nxt;
            dp_o <= dp_nxt;
        end
    end

    assign ca_o = seg[0];
    assign cb_o = seg[1];
    assign cc_o = seg[2];
    assign cd_o = seg[3];
    assign ce_o = seg[4];
    assign cf_o = seg[5];
    assign cg_o = seg[6];

endmodule
`default_nettype wire

// File: tb/tb_led_shift_disp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_led_shift_disp                                       |
// | Purpose  : Directed self-checking bench; three instances share the |
// |            buttons: [0] wrap/dot, [1] saturate/dot, [2] wrap/bar.  |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_led_shift_disp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn = 1'b0;
    logic btnl = 1'b1;
    logic btnr = 1'b1;

    logic [2:0][7:0]  an_w;
    logic [2:0][15:0] led_w;
    logic [2:0][6:0]  seg_w;
    logic [2:0]       dp_w;

    int n_pass  = 0;
    int n_total = 0;

    led_shift_disp #(.WRAP(1), .BAR_MODE(0)) u_wrap (
        .clk_i(clk), .arstn_i(rstn), .BTNL(btnl), .BTNR(btnr),
        .an_o(an_w[0]), .led_o(led_w[0]),
        .ca_o(seg_w[0][0]), .cb_o(seg_w[0][1]), .cc_o(seg_w[0][2]), .cd_o(seg_w[0][3]),
        .ce_o(seg_w[0][4]), .cf_o(seg_w[0][5]), .cg_o(seg_w[0][6]), .dp_o(dp_w[0])
    );

    led_shift_disp #(.WRAP(0), .BAR_MODE(0)) u_sat (
        .clk_i(clk), .arstn_i(rstn), .BTNL(btnl), .BTNR(btnr),
        .an_o(an_w[1]), .led_o(led_w[1]),
        .ca_o(seg_w[1][0]), .cb_o(seg_w[1][1]), .cc_o(seg_w[1][2]), .cd_o(seg_w[1][3]),
        .ce_o(seg_w[1][4]), .cf_o(seg_w[1][5]), .cg_o(seg_w[1][6]), .dp_o(dp_w[1])
    );

    led_shift_disp #(.WRAP(1), .BAR_MODE(1)) u_bar (
        .clk_i(clk), .arstn_i(rstn), .BTNL(btnl), .BTNR(btnr),
        .an_o(an_w[2]), .led_o(led_w[2]),
        .ca_o(seg_w[2][0]), .cb_o(seg_w[2][1]), .cc_o(seg_w[2][2]), .cd_o(seg_w[2][3]),
        .ce_o(seg_w[2][4]), .cf_o(seg_w[2][5]), .cg_o(seg_w[2][6]), .dp_o(dp_w[2])
    );

    // Active-low glyphs {g..a} used in expectations.
    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S4 = 7'h19, S5 = 7'h12;
    localparam logic [6:0] SC = 7'h46, SF = 7'h0E, SBLANK = 7'h7F;

    task automatic do_reset();
        rstn = 1'b0;
        btnl = 1'b1;
        btnr = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic press(input logic l, input logic r, input int low_cyc, input int gap);
        @(negedge clk);
        if (l) btnl = 1'b0;
        if (r) btnr = 1'b0;
        repeat (low_cyc) @(negedge clk);
        btnl = 1'b1;
        btnr = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    // Wait (bounded) until instance u drives digit d, then capture its segments and dp.
    task automatic read_digit(input int u, input int d, output logic [6:0] s, output logic p,
                              output bit ok);
        logic [7:0] want;
        want = ~(8'd1 << d);
        ok = 1'b0;
        s  = 7'h00;
        p  = 1'b0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            if (an_w[u] === want) begin
                s  = seg_w[u];
                p  = dp_w[u];
                ok = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] exp_an;
        rstn = 1'b0;
        btnl = 1'b1;
        btnr = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        n_total++; if (led_w[0] !== 16'h0001) $display("FAIL reset_led: got %h want 0001", led_w[0]); else n_pass++;
        n_total++; if (an_w[0] !== 8'hFF) $display("FAIL reset_an: got %h want FF", an_w[0]); else n_pass++;
        n_total++; if (seg_w[0] !== SBLANK || dp_w[0] !== 1'b1)
            $display("FAIL reset_seg: got seg %h dp %b want 7f 1", seg_w[0], dp_w[0]); else n_pass++;
        rstn = 1'b1;
        for (int d = 0; d < 8; d++) begin
            exp_an = ~(8'd1 << d);
            for (int c = 0; c < 4; c++) begin
                @(posedge clk); #1;
                n_total++;
                if (an_w[0] !== exp_an) $display("FAIL scan_an d%0d c%0d: got %h want %h", d, c, an_w[0], exp_an);
                else n_pass++;
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] old_led, new_led;
        logic [6:0]  s;
        logic        p;
        bit          ok, lat_ok;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            old_led = 16'h0001 << ((17 - k) % 16);
            new_led = 16'h0001 << (16 - k);
            @(negedge clk);
            btnr = 1'b0;
            lat_ok = 1'b1;
            for (int e = 1; e <= 6; e++) begin
                @(posedge clk); #1;
                if (led_w[0] !== old_led) lat_ok = 1'b0;
            end
            @(posedge clk); #1;
            n_total++;
            if (!lat_ok || led_w[0] !== new_led)
                $display("FAIL wrap_latency press%0d: early_ok %b got %h want %h", k, lat_ok, led_w[0], new_led);
            else n_pass++;
            repeat (13) @(negedge clk);
            btnr = 1'b1;
            repeat (200) @(negedge clk);
        end
        n_total++; if (led_w[0] !== 16'h1000) $display("FAIL wrap_led: got %h want 1000", led_w[0]); else n_pass++;
        read_digit(0, 2, s, p, ok);
        n_total++; if (!ok || s !== S4) $display("FAIL wrap_cnt0: ok %b got %h want %h", ok, s, S4); else n_pass++;
        for (int d = 3; d <= 5; d++) begin
            read_digit(0, d, s, p, ok);
            n_total++; if (!ok || s !== S0) $display("FAIL wrap_cnt%0d: ok %b got %h want %h", d - 2, ok, s, S0); else n_pass++;
        end
        read_digit(0, 0, s, p, ok);
        n_total++; if (!ok || s !== SC || p !== 1'b1)
            $display("FAIL wrap_dig0: ok %b got %h/%b want %h/1", ok, s, p, SC); else n_pass++;
        read_digit(0, 6, s, p, ok);
        n_total++; if (!ok || s !== SBLANK) $display("FAIL wrap_blank6: ok %b got %h want 7f", ok, s); else n_pass++;
    endtask

    task automatic test_saturate();
        logic [6:0] s;
        logic       p;
        bit         ok;
        do_reset();
        repeat (3) press(1'b0, 1'b1, 20, 30);
        n_total++; if (led_w[1] !== 16'h0001) $display("FAIL sat_led: got %h want 0001", led_w[1]); else n_pass++;
        n_total++; if (led_w[0] !== 16'h2000) $display("FAIL sat_wrapref_led: got %h want 2000", led_w[0]); else n_pass++;
        read_digit(1, 2, s, p, ok);
        n_total++; if (!ok || s !== S0) $display("FAIL sat_cnt: ok %b got %h want %h", ok, s, S0); else n_pass++;
        read_digit(1, 0, s, p, ok);
        n_total++; if (!ok || s !== S0 || p !== 1'b0)
            $display("FAIL sat_dp_low: ok %b got %h/%b want %h/0", ok, s, p, S0); else n_pass++;
        read_digit(1, 1, s, p, ok);
        n_total++; if (!ok || p !== 1'b1) $display("FAIL sat_dp_dig1: ok %b got %b want 1", ok, p); else n_pass++;
    endtask

    task automatic test_upper_bound();
        logic [6:0] s;
        logic       p;
        bit         ok;
        do_reset();
        repeat (16) press(1'b1, 1'b0, 20, 20);
        n_total++; if (led_w[1] !== 16'h8000) $display("FAIL top_sat_led: got %h want 8000", led_w[1]); else n_pass++;
        n_total++; if (led_w[0] !== 16'h0001) $display("FAIL top_wrap_led: got %h want 0001", led_w[0]); else n_pass++;
        read_digit(1, 0, s, p, ok);
        n_total++; if (!ok || s !== SF || p !== 1'b0)
            $display("FAIL top_sat_dig0: ok %b got %h/%b want %h/0", ok, s, p, SF); else n_pass++;
        read_digit(1, 2, s, p, ok);
        n_total++; if (!ok || s !== SF) $display("FAIL top_sat_cnt: ok %b got %h want %h", ok, s, SF); else n_pass++;
        read_digit(0, 2, s, p, ok);
        n_total++; if (!ok || s !== S0) $display("FAIL top_wrap_cnt0: ok %b got %h want %h", ok, s, S0); else n_pass++;
        read_digit(0, 3, s, p, ok);
        n_total++; if (!ok || s !== S1) $display("FAIL top_wrap_cnt1: ok %b got %h want %h", ok, s, S1); else n_pass++;
    endtask

    task automatic test_glitch_cancel();
        logic [6:0] s;
        logic       p;
        bit         ok;
        do_reset();
        press(1'b1, 1'b0, 2, 30);
        n_total++; if (led_w[0] !== 16'h0001) $display("FAIL glitch_led: got %h want 0001", led_w[0]); else n_pass++;
        press(1'b1, 1'b1, 20, 30);
        n_total++; if (led_w[0] !== 16'h0001) $display("FAIL cancel_led: got %h want 0001", led_w[0]); else n_pass++;
        read_digit(0, 2, s, p, ok);
        n_total++; if (!ok || s !== S0) $display("FAIL cancel_cnt: ok %b got %h want %h", ok, s, S0); else n_pass++;
    endtask

    task automatic test_bar();
        logic [6:0] s;
        logic       p;
        bit         ok;
        do_reset();
        repeat (5) press(1'b1, 1'b0, 20, 20);
        n_total++; if (led_w[2] !== 16'h003F) $display("FAIL bar_led: got %h want 003f", led_w[2]); else n_pass++;
        n_total++; if (led_w[0] !== 16'h0020) $display("FAIL bar_dotref_led: got %h want 0020", led_w[0]); else n_pass++;
        read_digit(2, 0, s, p, ok);
        n_total++; if (!ok || s !== S5) $display("FAIL bar_dig0: ok %b got %h want %h", ok, s, S5); else n_pass++;
        read_digit(2, 1, s, p, ok);
        n_total++; if (!ok || s !== S0) $display("FAIL bar_dig1: ok %b got %h want %h", ok, s, S0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [6:0] s;
        logic       p;
        bit         ok, still;
        do_reset();
        @(negedge clk);
        btnl = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        n_total++; if (led_w[0] !== 16'h0001) $display("FAIL mid_after_rst: got %h want 0001", led_w[0]); else n_pass++;
        still = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); #1;
            if (led_w[0] !== 16'h0001) still = 1'b0;
        end
        n_total++; if (!still) $display("FAIL mid_no_early_move: got %h want 0001", led_w[0]); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (led_w[0] !== 16'h0002) $display("FAIL mid_one_move: got %h want 0002", led_w[0]); else n_pass++;
        repeat (60) @(negedge clk);
        btnl = 1'b1;
        repeat (30) @(negedge clk);
        n_total++; if (led_w[0] !== 16'h0002) $display("FAIL mid_no_repeat: got %h want 0002", led_w[0]); else n_pass++;
        read_digit(0, 2, s, p, ok);
        n_total++; if (!ok || s !== S1) $display("FAIL mid_cnt: ok %b got %h want %h", ok, s, S1); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_saturate();
        test_upper_bound();
        test_glitch_cancel();
        test_bar();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire
